multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM that sequences the shared ALU/memory/register-file datapath over several cycles per
//  instruction, using the same 6-bit opcode map and control encodings as the single-cycle decoder.
//  Sits between the instruction register (opcode, ALU zero flag) and the datapath muxes/enables.
//  Stalls on a memory ready handshake and counts retired instructions.
// PARAMETERS
//  CNT_W         32  width of the retired-instruction counter
//  ILLEGAL_HALT  0   0: an unknown opcode is skipped (back to FETCH); 1: the FSM parks in HALT until reset
// PORTS
//  clk_i        in   1      clock, all state updates on rising edge
//  rst_i        in   1      synchronous reset, active-low
//  instr_op_i   in   6      opcode field of the instruction register, sampled in DECODE
//  zero_i       in   1      ALU zero flag, used in EXEC for branches
//  mem_ready_i  in   1      memory done: read data valid / write accepted this cycle
//  PCWrite_o    out  1      PC load enable
//  IRWrite_o    out  1      instruction register load enable
//  IorD_o       out  1      memory address select: 0=PC, 1=ALUOut
//  ALUSrcA_o    out  1      0=PC, 1=rs
//  ALUSrcB_o    out  2      00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//  ALU_op_o     out  2      00=add, 01=sub (branch compare), 10=use funct
//  PCSource_o   out  2      00=ALU result, 01=ALUOut (branch target), 10=jump target
//  Branch_o     out  2      00=none, 01=beq, 10=bne (valid in EXEC)
//  MemRead_o    out  1      memory read request
//  MemWrite_o   out  1      memory write request
//  RegWrite_o   out  1      register file write enable
//  RegDst_o     out  2      00=rt, 01=rd, 10=$31
//  MemtoReg_o   out  2      00=ALUOut, 01=MDR, 10=PC (link)
//  state_o      out  3      current state encoding
//  illegal_o    out  1      one-cycle pulse in DECODE on an unknown opcode
//  instr_cnt_o  out  CNT_W  retired-instruction count
// BEHAVIOUR
//  States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Opcode is registered into op_q in DECODE.
//  Opcodes: R=000000, addi=001001, lw=101100, sw=100100, beq=000110, bne=000101, j=000111, jal=000011.
//  Reset: rst_i==0 at a clock edge sets state->FETCH, op_q->0, instr_cnt_o->0.
//   While rst_i==0, every control output is forced to 0 combinationally.
//  Outputs are combinational from state/op_q (plus zero_i and mem_ready_i where noted). Any output not listed is 0.
//  FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_op=00, PCSource=00.
//   IRWrite=PCWrite=mem_ready_i. Move to DECODE on mem_ready_i; otherwise hold (stall, unbounded).
//  DECODE: ALUSrcA=0, ALUSrcB=11, ALU_op=00 (branch target -> ALUOut).
//   R/addi/lw/sw/beq/bne -> EXEC.
//   j: PCWrite=1, PCSource=10 -> FETCH.
//   jal: additionally RegWrite=1, RegDst=10, MemtoReg=10 (PC already +4) -> FETCH.
//   Unknown opcode: illegal_o=1, no writes -> FETCH, or HALT if ILLEGAL_HALT=1.
//  EXEC:
//   R: ALUSrcA=1, ALUSrcB=00, ALU_op=10 -> WB.
//   addi/lw/sw: ALUSrcA=1, ALUSrcB=10, ALU_op=00. addi -> WB; lw/sw -> MEM.
//   beq/bne: ALUSrcA=1, ALUSrcB=00, ALU_op=01, PCSource=01, Branch=01/10.
//    PCWrite = beq&zero_i | bne&~zero_i. -> FETCH.
//  MEM: IorD=1. lw: MemRead=1; sw: MemWrite=1. Request held until mem_ready_i.
//   Then lw -> WB, sw -> FETCH.
//  WB: RegWrite=1.
//   R: RegDst=01, MemtoReg=00. addi: RegDst=00, MemtoReg=00. lw: RegDst=00, MemtoReg=01. -> FETCH.
//  HALT: all outputs 0; left only by reset.
//  instr_cnt_o increments by 1 on every transition into FETCH from DECODE/EXEC/MEM/WB.
//   This includes skipped illegal opcodes and excludes reset. Wraps modulo 2^CNT_W.
//  Latency with mem_ready_i tied 1: R/addi 4 cycles, lw 5, sw 4, beq/bne 3, j/jal 2.
//   Each memory wait cycle adds 1.
//  mem_ready_i is ignored outside FETCH/MEM. instr_op_i is ignored outside DECODE.
// TESTING
//  R-type, mem_ready_i=1 -> states 0,1,2,4,0; RegWrite=1 with RegDst=01 only in WB; instr_cnt_o 0->1.
//  lw, mem_ready_i low 2 cycles in MEM -> MEM held 3 cycles with MemRead=1, IorD=1;
//   then WB with MemtoReg=01; total 7 cycles.
//  beq with zero_i=1 -> PCWrite=1, PCSource=01 in EXEC; beq with zero_i=0 -> PCWrite=0;
//   bne mirrored; each takes 3 cycles.
//  jal -> DECODE asserts PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10; back in FETCH after 2 cycles.
//  opcode 111111: with ILLEGAL_HALT=0 -> illegal_o pulse, FETCH next, count+1;
//   with ILLEGAL_HALT=1 -> state_o=5 held 10 cycles, outputs 0.
//  rst_i=0 mid-MEM of sw -> MemWrite drops to 0 that cycle; next state FETCH, instr_cnt_o=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the shared ALU/memory/register-file datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB per instruction and counts retired instructions.
module multicycle_ctrl #(
  parameter int unsigned CNT_W        = 32,
  parameter bit          ILLEGAL_HALT = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       instr_op_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             PCWrite_o,
  output logic             IRWrite_o,
  output logic             IorD_o,
  output logic             ALUSrcA_o,
  output logic [1:0]       ALUSrcB_o,
  output logic [1:0]       ALU_op_o,
  output logic [1:0]       PCSource_o,
  output logic [1:0]       Branch_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             RegWrite_o,
  output logic [1:0]       RegDst_o,
  output logic [1:0]       MemtoReg_o,
  output logic [2:0]       state_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpAddi = 6'b001001;
  localparam logic [5:0] OpLw   = 6'b101100;
  localparam logic [5:0] OpSw   = 6'b100100;
  localparam logic [5:0] OpBeq  = 6'b000110;
  localparam logic [5:0] OpBne  = 6'b000101;
  localparam logic [5:0] OpJ    = 6'b000111;
  localparam logic [5:0] OpJal  = 6'b000011;

  state_e           state_q, state_d;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: if (mem_ready_i) state_d = StDecode;
      StDecode: begin
        case (instr_op_i)
          OpR, OpAddi, OpLw, OpSw, OpBeq, OpBne: state_d = StExec;
          OpJ, OpJal:                            state_d = StFetch;
          default: state_d = ILLEGAL_HALT ? StHalt : StFetch;
        endcase
      end
      StExec: begin
        case (op_q)
          OpR, OpAddi: state_d = StWb;
          OpLw, OpSw:  state_d = StMem;
          default:     state_d = StFetch;
        endcase
      end
      StMem: if (mem_ready_i) state_d = (op_q == OpLw) ? StWb : StFetch;
      StWb:   state_d = StFetch;
      StHalt: state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // An instruction retires whenever the FSM returns to FETCH (illegal skips included).
  assign retire = (state_d == StFetch) &&
                  (state_q inside {StDecode, StExec, StMem, StWb});

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= StFetch;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) op_q <= instr_op_i;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign state_o     = state_q;
  assign instr_cnt_o = cnt_q;

  always_comb begin
    PCWrite_o  = 1'b0;
    IRWrite_o  = 1'b0;
    IorD_o     = 1'b0;
    ALUSrcA_o  = 1'b0;
    ALUSrcB_o  = 2'b00;
    ALU_op_o   = 2'b00;
    PCSource_o = 2'b00;
    Branch_o   = 2'b00;
    MemRead_o  = 1'b0;
    MemWrite_o = 1'b0;
    RegWrite_o = 1'b0;
    RegDst_o   = 2'b00;
    MemtoReg_o = 2'b00;
    illegal_o  = 1'b0;
    if (rst_i) begin
      unique case (state_q)
        StFetch: begin
          MemRead_o = 1'b1;
          ALUSrcB_o = 2'b01;
          IRWrite_o = mem_ready_i;
          PCWrite_o = mem_ready_i;
        end
        StDecode: begin
          // DECODE acts on the live opcode; op_q only holds it from EXEC onward.
          ALUSrcB_o = 2'b11;
          case (instr_op_i)
            OpJ: begin
              PCWrite_o  = 1'b1;
              PCSource_o = 2'b10;
            end
            OpJal: begin
              PCWrite_o  = 1'b1;
              PCSource_o = 2'b10;
              RegWrite_o = 1'b1;
              RegDst_o   = 2'b10;
              MemtoReg_o = 2'b10;
            end
            OpR, OpAddi, OpLw, OpSw, OpBeq, OpBne: ;
            default: illegal_o = 1'b1;
          endcase
        end
        StExec: begin
          ALUSrcA_o = 1'b1;
          case (op_q)
            OpR: ALU_op_o = 2'b10;
            OpAddi, OpLw, OpSw: ALUSrcB_o = 2'b10;
            OpBeq: begin
              ALU_op_o   = 2'b01;
              PCSource_o = 2'b01;
              Branch_o   = 2'b01;
              PCWrite_o  = zero_i;
            end
            OpBne: begin
              ALU_op_o   = 2'b01;
              PCSource_o = 2'b01;
              Branch_o   = 2'b10;
              PCWrite_o  = ~zero_i;
            end
            default: ;
          endcase
        end
        StMem: begin
          IorD_o     = 1'b1;
          MemRead_o  = (op_q == OpLw);
          MemWrite_o = (op_q == OpSw);
        end
        StWb: begin
          RegWrite_o = 1'b1;
          case (op_q)
            OpR:     RegDst_o   = 2'b01;
            OpLw:    MemtoReg_o = 2'b01;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
